// File: rtl/dms_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// Package : dms_ctrl_pkg
// Brief   : Shared state encoding, code type and defaults for the DMS lock controller.
// Rev     : 1.0
//------------------------------------------------------------------
package dms_ctrl_pkg;

  localparam int c_win_len      = 64;
  localparam int c_acq_cycles   = 256;
  localparam int c_lock_tol     = 2;
  localparam int c_unlock_tol   = 8;
  localparam int c_lock_windows = 4;
  localparam int c_code_w       = 4;
  localparam int c_code_max     = 15;
  localparam int c_code_track   = 4;
  localparam int c_max_windows  = 1024;

  typedef logic [c_code_w-1:0] cp_code_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dms_win_counter.sv
`default_nettype none
//------------------------------------------------------------------
// Module : dms_win_counter
// Brief  : Synchronizes PFD up/down and counts them over fixed windows.
// Rev    : 1.0
//------------------------------------------------------------------
module dms_win_counter
  import dms_ctrl_pkg::*;
#(
  parameter int WIN_LEN = c_win_len,
  parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic                    active,
  input  logic                    up,
  input  logic                    down,
  output logic                    win_done,
  output logic signed [CNT_W:0]   diff
);

  logic [1:0]       r_up_sync;
  logic [1:0]       r_dn_sync;
  logic [CNT_W-1:0] r_up_cnt;
  logic [CNT_W-1:0] r_dn_cnt;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [CNT_W-1:0] w_up_tot;
  logic [CNT_W-1:0] w_dn_tot;

  // Totals include the current sample so the window decision sees all WIN_LEN samples.
  assign w_up_tot = r_up_cnt + CNT_W'(r_up_sync[1]);
  assign w_dn_tot = r_dn_cnt + CNT_W'(r_dn_sync[1]);
  assign win_done = active && (r_smp_cnt == CNT_W'(WIN_LEN - 1));
  assign diff     = $signed({1'b0, w_up_tot}) - $signed({1'b0, w_dn_tot});

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_up_sync <= '0;
      r_dn_sync <= '0;
      r_up_cnt  <= '0;
      r_dn_cnt  <= '0;
      r_smp_cnt <= '0;
    end else begin
      r_up_sync <= {r_up_sync[0], up};
      r_dn_sync <= {r_dn_sync[0], down};
      if (!active || win_done) begin
        r_up_cnt  <= '0;
        r_dn_cnt  <= '0;
        r_smp_cnt <= '0;
      end else begin
        r_up_cnt  <= w_up_tot;
        r_dn_cnt  <= w_dn_tot;
        r_smp_cnt <= r_smp_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dms_lock_ctrl.sv
`default_nettype none
//------------------------------------------------------------------
// Module : dms_lock_ctrl
// Brief  : Sequences PFD/charge-pump from acquisition gain to tracking gain and flags lock.
// Rev    : 1.0
//------------------------------------------------------------------
module dms_lock_ctrl
  import dms_ctrl_pkg::*;
#(
  parameter int WIN_LEN      = c_win_len,
  parameter int ACQ_CYCLES   = c_acq_cycles,
  parameter int LOCK_TOL     = c_lock_tol,
  parameter int UNLOCK_TOL   = c_unlock_tol,
  parameter int LOCK_WINDOWS = c_lock_windows,
  parameter int CODE_W       = c_code_w,
  parameter int CODE_MAX     = c_code_max,
  parameter int CODE_TRACK   = c_code_track,
  parameter int MAX_WINDOWS  = c_max_windows
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              up,
  input  logic              down,
  output logic              pfd_en,
  output logic [CODE_W-1:0] cp_code,
  output logic              locked,
  output logic              fail,
  output logic [2:0]        state
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam int ACQ_W = $clog2(ACQ_CYCLES + 1);
  localparam int WTO_W = $clog2(MAX_WINDOWS + 1);
  localparam int BAL_W = $clog2(LOCK_WINDOWS + 1);

  state_t              r_state;
  logic                r_pfd_en;
  logic [CODE_W-1:0]   r_cp_code;
  logic                r_locked;
  logic                r_fail;
  logic [ACQ_W-1:0]    r_acq_cnt;
  logic [WTO_W-1:0]    r_wto_cnt;
  logic [BAL_W-1:0]    r_bal_cnt;

  logic                w_active;
  logic                w_win_done;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W:0]      w_abs_d;
  logic                w_balanced;
  logic [CODE_W-1:0]   w_cp_step;
  logic [BAL_W-1:0]    w_bal_next;
  logic [WTO_W-1:0]    w_wto_next;

  assign w_active = enable && ((r_state == ST_TRACK) || (r_state == ST_LOCKED));

  dms_win_counter #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) u_win (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .active   (w_active),
    .up       (up),
    .down     (down),
    .win_done (w_win_done),
    .diff     (w_diff)
  );

  always_comb begin
    w_abs_d = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    w_balanced = (w_abs_d <= (CNT_W+1)'(LOCK_TOL));
    w_cp_step  = CODE_W'(CODE_MAX);
    w_bal_next = '0;
    if (w_balanced) begin
      w_cp_step  = (r_cp_code > CODE_W'(CODE_TRACK)) ? r_cp_code - 1'b1 : CODE_W'(CODE_TRACK);
      w_bal_next = (r_bal_cnt == BAL_W'(LOCK_WINDOWS)) ? r_bal_cnt : r_bal_cnt + 1'b1;
    end
    w_wto_next = (r_wto_cnt == WTO_W'(MAX_WINDOWS)) ? r_wto_cnt : r_wto_cnt + 1'b1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pfd_en  <= 1'b0;
      r_cp_code <= '0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
      r_acq_cnt <= '0;
      r_wto_cnt <= '0;
      r_bal_cnt <= '0;
    end else if (!enable) begin
      r_state   <= ST_IDLE;
      r_pfd_en  <= 1'b0;
      r_cp_code <= '0;
      r_locked  <= 1'b0;
      r_fail    <= 1'b0;
      r_acq_cnt <= '0;
      r_wto_cnt <= '0;
      r_bal_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_ACQ;
          r_pfd_en  <= 1'b1;
          r_cp_code <= CODE_W'(CODE_MAX);
          r_acq_cnt <= '0;
        end
        ST_ACQ: begin
          if (r_acq_cnt == ACQ_W'(ACQ_CYCLES - 1)) begin
            r_state   <= ST_TRACK;
            r_wto_cnt <= '0;
            r_bal_cnt <= '0;
          end else begin
            r_acq_cnt <= r_acq_cnt + 1'b1;
          end
        end
        ST_TRACK: begin
          if (w_win_done) begin
            r_cp_code <= w_cp_step;
            r_bal_cnt <= w_bal_next;
            r_wto_cnt <= w_wto_next;
            // Lock takes priority over a timeout landing on the same window.
            if ((w_bal_next == BAL_W'(LOCK_WINDOWS)) && (w_cp_step == CODE_W'(CODE_TRACK))) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else if (w_wto_next == WTO_W'(MAX_WINDOWS)) begin
              r_state   <= ST_FAIL;
              r_pfd_en  <= 1'b0;
              r_cp_code <= '0;
              r_fail    <= 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (w_win_done && (w_abs_d > (CNT_W+1)'(UNLOCK_TOL))) begin
            r_state   <= ST_ACQ;
            r_locked  <= 1'b0;
            r_cp_code <= CODE_W'(CODE_MAX);
            r_acq_cnt <= '0;
          end
        end
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pfd_en  = r_pfd_en;
  assign cp_code = r_cp_code;
  assign locked  = r_locked;
  assign fail    = r_fail;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: doc/dms_lock_ctrl.md
# dms_lock_ctrl

Lock-acquisition controller for the DMS phase-detector / charge-pump loop, clocked by `refclk`. It enables the PFD, drives the charge-pump current code that sets `ig`, and counts synchronized `up`/`down` pulses over fixed windows. From those counts it steps the pump from a high-gain acquisition code down to a low-gain tracking code, and it declares lock, loss of lock, or acquisition timeout. It sits beside the PFD/charge-pump datapath and is the only block that sequences it.

## Interface
- `WIN_LEN`, 64: `refclk` samples per evaluation window (≥ 4).
- `ACQ_CYCLES`, 256: settle cycles in ACQ at `CODE_MAX` before windowing starts.
- `LOCK_TOL`, 2: max |up−down| per window counted as balanced.
- `UNLOCK_TOL`, 8: |up−down| above this in LOCKED means loss of lock.
- `LOCK_WINDOWS`, 4: consecutive balanced windows required for lock.
- `CODE_W`, 4: charge-pump code width.
- `CODE_MAX`, 15: acquisition code.
- `CODE_TRACK`, 4: tracking code (`CODE_TRACK` ≤ `CODE_MAX`).
- `MAX_WINDOWS`, 1024: TRACK windows allowed before FAIL.
- `refclk` input, 1: sole clock.
- `rst_n` input, 1: asynchronous active-low reset.
- `enable` input, 1: level; starts the sequence and holds it running.
- `up` input, 1: PFD up; asynchronous to `refclk`.
- `down` input, 1: PFD down; asynchronous to `refclk`.
- `pfd_en` output, 1: PFD enable.
- `cp_code` output, `CODE_W`: charge-pump current code.
- `locked` output, 1: lock indication.
- `fail` output, 1: sticky acquisition timeout.
- `state` output, 3: current FSM state (for debug and binds).

## Operation
- `up` and `down` each pass through a 2-flop synchronizer. The synchronized levels are counted once per `refclk` while windowing is active.
- If both are high in the same cycle, both counters increment.
- States:
  - IDLE: `pfd_en`=0, `cp_code`=0, counters cleared. `enable`=1 → ACQ.
  - ACQ: `pfd_en`=1, `cp_code`=`CODE_MAX`. After `ACQ_CYCLES` cycles → TRACK, with window, balance and window-timeout counters cleared.
  - TRACK, at each window end:
    - If |d| ≤ `LOCK_TOL`: increment the balance count and decrement `cp_code` by 1, floored at `CODE_TRACK`.
    - Otherwise: clear the balance count and restore `cp_code` to `CODE_MAX`.
    - If the balance count reaches `LOCK_WINDOWS` and `cp_code`==`CODE_TRACK` → LOCKED.
    - Else if the window-timeout count reaches `MAX_WINDOWS` → FAIL.
  - LOCKED: `locked`=1, `cp_code`=`CODE_TRACK`. At a window end with |d| > `UNLOCK_TOL` → ACQ, with `locked` cleared.
  - FAIL: `pfd_en`=0, `cp_code`=0, `fail`=1. Exits only through `enable`=0.
- In any state, `enable`=0 → IDLE in one cycle, which clears counters and `fail`.
- Arithmetic: d = up_cnt − dn_cnt.
  - up_cnt and dn_cnt are $clog2(WIN_LEN+1) bits, unsigned.
  - d is one bit wider, signed; |d| is taken on the signed value.
  - Counters never wrap: the window ends exactly at `WIN_LEN` samples.

## Timing
- Reset values: `pfd_en`=0, `cp_code`=0, `locked`=0, `fail`=0, `state`=IDLE.
- All outputs are registered.
- PFD edge to counter: 2 cycles for the synchronizer plus 1 cycle to count.
- Window evaluation uses the counts including the last sample. The decision and new `cp_code` appear on the cycle after the `WIN_LEN`-th sample. Counters restart on that same cycle, so there is no gap.
- `enable` rising to `pfd_en`=1 and `cp_code`=`CODE_MAX`: 1 cycle.
- A lock decision and a timeout can land on the same window end. Lock wins.
- An `enable` drop on a window-end cycle overrides the window decision.
- Asserting `rst_n` mid-operation returns all outputs to their reset values immediately, asynchronously. Release is synchronous to `refclk`.

## Structure
- Package `dms_ctrl_pkg` holds:
  - the state enum: IDLE=0, ACQ=1, TRACK=2, LOCKED=3, FAIL=4, stored in 3 bits;
  - a `cp_code_t` typedef;
  - default parameter constants.
- Sub-module `dms_win_counter` contains the synchronizers, up/down counters and window timer. It outputs `win_done` and the signed `diff`.
- The top level holds the FSM and the `cp_code` stepping logic.

## Test plan
- **Reset/idle:** `rst_n`=0, then release with `enable`=0 → all outputs 0 and `state`=IDLE indefinitely.
- **Clean acquisition:** `enable`=1 with `up`/`down` held 0 →
  - `cp_code`=15 for 256 cycles;
  - then 15→14→…→4 across 11 windows;
  - `locked`=1 at the end of the window where the balance count reaches 4 and `cp_code`==4.
- **Imbalance in TRACK:** drive `up` high for 10 of 64 samples during one window → `cp_code` returns to 15 and the balance count resets. Lock arrives correspondingly later.
- **Loss of lock:** once LOCKED, drive `up` for 9 of 64 samples → `locked`=0 and `state`=ACQ one cycle after the window end. Drive 8 of 64 instead → stays LOCKED.
- **Timeout:**
  - Set `MAX_WINDOWS`=8 and drive `up` continuously → `fail`=1, `pfd_en`=0 after 8 TRACK windows.
  - Drop `enable` → `fail` clears, state returns to IDLE.
- **Mid-operation reset and enable:** assert `rst_n` low mid-window in TRACK → outputs 0 asynchronously. Separately, drop `enable` on a window-end cycle → IDLE, with no `cp_code` update.
